decoder_serial_adder: RTL and testbench
=======================================

# decoder_serial_adder

Parametrised bit-serial adder whose per-bit full adder is built from a 3-to-8 minterm decoder, extending the decoder-based half adder to a multi-bit, multi-cycle sequential operator. It accepts two WIDTH-bit operands on a start strobe, processes one bit per clock LSB-first, and returns a registered sum and carry-out with a one-cycle done pulse. It is intended as a small-area arithmetic unit for control paths where latency is not critical.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load-and-go strobe; honoured only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- sub  input  1  subtract select; sampled with start. Present only when DECODER_SERIAL_ADDER_SUB_EN is defined.
- busy  output  1  high while in RUN or DONE; reset 0.
- done  output  1  one-cycle completion pulse; reset 0.
- sum  output  WIDTH  registered result; reset 0.
- carry  output  1  registered carry-out (no-borrow in subtract); reset 0.

## Operation
- Bit cell: the inputs {a_bit, b_bit, c} drive a 3-to-8 one-hot decoder d[7:0] with index = a_bit·4 + b_bit·2 + c.
  - sum_bit = d1|d2|d4|d7.
  - carry_next = d3|d5|d6|d7.
  - No `+` operator is used in the datapath.
- State machine: IDLE, RUN, DONE.
  - IDLE: on start=1, load shift registers sa←a and sb←b. Clear the result shift register. Set carry register c←0, and the bit counter ←0. Go to RUN.
  - RUN: each cycle, feed sa[0], sb[0], c to the bit cell.
    - Shift sa and sb right by one.
    - Shift sum_bit into the result register MSB, shifting right.
    - c←carry_next; counter increments.
    - When the counter reaches WIDTH-1 on the current edge, go to DONE.
  - DONE: copy the result register to sum and c to carry. Assert done for exactly this cycle. Next cycle go to IDLE.
- sum and carry hold their value from completion until the next DONE. They do not change during RUN.
- start is ignored in RUN and DONE. There is no queuing.
- Counter width is $clog2(WIDTH+1). For WIDTH=1, RUN lasts exactly one cycle.
- Result is modulo 2^WIDTH; carry is the carry out of bit WIDTH-1.
- Reset (asynchronous, any state) forces IDLE, clears all registers and outputs, and aborts any operation in progress. No done is issued for the aborted operation.

## Timing
- Let edge E be the rising edge sampling start=1 in IDLE.
- busy is high from after E through the DONE cycle, i.e. WIDTH+1 cycles.
- done is high in the cycle after edge E+WIDTH. Latency from start is WIDTH+1 cycles.
- sum and carry are valid in the same cycle done is high.
- First cycle a new start can be accepted: the IDLE cycle after DONE. The minimum issue interval is WIDTH+2 cycles.
- start asserted in the DONE cycle is dropped.

## Configuration
- DECODER_SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1 at acceptance, the block loads sb←~b and c←1, computing a−b in two's complement.
  - carry=1 means no borrow (a≥b unsigned).
  - sub=0 behaves as add.
- Not defined: there is no sub port and the block always adds. The gate count excludes the inverter mux.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h0F, start for 1 cycle -> done exactly 9 cycles after the accepting edge; sum=8'h4B, carry=0; busy high 9 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1.
- Start re-pulsed with a=8'h01, b=8'h01 on cycles 3 and 9 of a running operation -> both ignored; the original result is delivered unchanged, and only one done pulse occurs.
- rst_n low for 1 cycle midway through RUN -> busy, done, sum, carry all 0 immediately. A new start of a=8'h10, b=8'h20 then completes with sum=8'h30 after 9 cycles.
- With the macro defined: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, carry=0. sub=1, a=8'h07, b=8'h05 -> sum=8'h02, carry=1.
- Exhaustive sweep of all a, b with WIDTH=4, back-to-back starts issued in the IDLE cycle after each done -> every result matches a reference add (and subtract if the macro is defined). The issue interval is 6 cycles.

Source files
------------

// File: rtl/decoder_serial_adder.sv
// ---------------------------------------------------------------------------
// decoder_serial_adder
//
// Bit-serial adder. Two WIDTH-bit operands are captured on a start strobe
// and summed one bit per clock, LSB first. The per-bit full adder is a
// 3-to-8 one-hot minterm decoder followed by two OR-reductions. There is
// no '+' in the datapath. The registered sum and carry-out are presented
// together with a single-cycle done pulse.
//
// Optional feature macro: DECODER_SERIAL_ADDER_SUB_EN
//   When defined, the block adds a 'sub' input. With sub=1 at acceptance,
//   the block computes a-b in two's complement by loading ~b with carry-in
//   1. carry=1 then means no borrow.
//   When undefined, the 'sub' port does not exist and the block always adds.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      load-and-go strobe; honoured only in IDLE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   sub    in   1      subtract select (only with DECODER_SERIAL_ADDER_SUB_EN)
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result, held until the next completion
//   carry  out  1      registered carry-out of bit WIDTH-1
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | one operand bit processed per clock, LSB first
//   DONE    | result valid, done asserted for this single cycle
// ---------------------------------------------------------------------------
module decoder_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DECODER_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Minterm selections of the one-hot decoder output d[7:0]:
  // sum   = d1|d2|d4|d7 (odd parity of {a,b,c})
  // carry = d3|d5|d6|d7 (two or more inputs set)
  localparam logic [7:0] SUM_MASK   = 8'b1001_0110;
  localparam logic [7:0] CARRY_MASK = 8'b1110_1000;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [2:0]       idx;
  logic [7:0]       d;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Bit cell: decoder plus OR-reductions.
  always_comb begin
    idx        = {sa[0], sb[0], c};
    d          = 8'd1 << idx;
    sum_bit    = |(d & SUM_MASK);
    carry_next = |(d & CARRY_MASK);
    // Result register shifts right, with the new bit entering at the MSB.
    // The concatenation form also works for WIDTH=1.
    res_ext    = {sum_bit, res};
    res_shift  = res_ext[WIDTH:1];
  end

  // Operand B and carry-in seen by the first bit.
`ifdef DECODER_SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub;
  end
`else
  always_comb begin
    b_load = b;
    c_load = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b_load;
            res   <= '0;
            c     <= c_load;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_shift;
          c   <= carry_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Publish on the same edge that enters DONE. The result is then
            // visible in the DONE cycle alongside the done pulse.
            sum   <= res_shift;
            carry <= carry_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DONE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_decoder_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_decoder_serial_adder
//
// Drives an 8-bit and a 4-bit instance of decoder_serial_adder. Results are
// compared against plain-arithmetic add/subtract, covering:
//   - latency
//   - busy window
//   - single done pulse
//   - result hold
//   - ignored restarts
//   - mid-run reset
//   - an exhaustive back-to-back sweep at WIDTH=4
// ---------------------------------------------------------------------------
module tb_decoder_serial_adder;

`ifdef DECODER_SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
`ifdef DECODER_SERIAL_ADDER_SUB_EN
  logic       sub8 = 1'b0;
  logic       sub4 = 1'b0;
`endif
  logic       busy8, done8, carry8;
  logic [7:0] sum8;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] prev8 = '0;

  always #5 clk = ~clk;

  decoder_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef DECODER_SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  decoder_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
`ifdef DECODER_SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, sum} for a w-bit operation, in bits [w:0].
  function automatic logic [32:0] ref_op(input int w, input logic [31:0] x,
                                         input logic [31:0] y, input bit s);
    logic [32:0] m;
    logic [32:0] r;
    m = (33'd1 << w) - 33'd1;
    if (s) r = {1'b0, x} + ({1'b0, ~y} & m) + 33'd1;
    else   r = {1'b0, x} + {1'b0, y};
    return r & ((m << 1) | 33'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation. restart[k] re-pulses start (a=b=1) in cycle k after
  // the accepting edge. Cycle k lies between edges E+k-1 and E+k.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit s,
                      input logic [15:0] restart, input string tag);
    logic [32:0] r;
    int lat, busy_n, done_n;
    r = ref_op(8, {24'd0, x}, {24'd0, y}, s);
    tick();
    start8 = 1'b1; a8 = x; b8 = y;
`ifdef DECODER_SERIAL_ADDER_SUB_EN
    sub8 = s;
`endif
    tick();
    start8 = 1'b0;
    lat = -1; busy_n = 0; done_n = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (lat < 0) begin
          lat = k;
          chk({tag, "_res"}, {55'd0, carry8, sum8}, {55'd0, r[8:0]});
        end
      end else if (lat < 0) begin
        chk({tag, "_hold"}, {55'd0, carry8, sum8}, {55'd0, prev8});
      end
      start8 = restart[k];
      if (restart[k]) begin
        a8 = 8'h01; b8 = 8'h01;
`ifdef DECODER_SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
      end
      tick();
    end
    start8 = 1'b0;
    prev8 = r[8:0];
    chk({tag, "_latency"}, 64'(lat), 64'd9);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd9);
    chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, "_kept"}, {55'd0, carry8, sum8}, {55'd0, prev8});
  endtask

  initial begin
    logic [32:0] r;
    int n, dn;

    // Reset state.
    #1;
    chk("rst8_busy", {63'd0, busy8}, 64'd0);
    chk("rst8_done", {63'd0, done8}, 64'd0);
    chk("rst8_out", {55'd0, carry8, sum8}, 64'd0);
    chk("rst4_out", {58'd0, busy4, done4, carry4, sum4}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'h3C, 8'h0F, 1'b0, 16'h0000, "add_3c_0f");
    run8(8'hFF, 8'h01, 1'b0, 16'h0000, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b0, 16'h0000, "add_ff_ff");
    // Restart pulses in cycle 3 (RUN) and cycle 9 (DONE) must both be dropped.
    run8(8'(($urandom)), 8'($urandom), 1'b0, 16'h0208, "restart_ignored");

    // Abort a run with an asynchronous reset pulse.
    tick();
    start8 = 1'b1; a8 = 8'hA5; b8 = 8'h7B;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_done", {63'd0, done8}, 64'd0);
    chk("abort_out", {55'd0, carry8, sum8}, 64'd0);
    prev8 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 || busy8) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run8(8'h10, 8'h20, 1'b0, 16'h0000, "after_abort");

    if (SUB_EN) begin
      run8(8'h05, 8'h07, 1'b1, 16'h0000, "sub_05_07");
      run8(8'h07, 8'h05, 1'b1, 16'h0000, "sub_07_05");
    end

    for (int i = 0; i < 12; i++) begin
      run8(8'($urandom), 8'($urandom), SUB_EN ? bit'($urandom_range(0, 1)) : 1'b0,
           16'h0000, "rand8");
    end

    // Exhaustive WIDTH=4 sweep. Each start is issued in the IDLE cycle after done.
    tick();
    for (int s = 0; s <= int'(SUB_EN); s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          r = ref_op(4, 32'(x), 32'(y), bit'(s));
          start4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
`ifdef DECODER_SERIAL_ADDER_SUB_EN
          sub4 = bit'(s);
`endif
          tick();
          start4 = 1'b0;
          n = 1;
          while (!done4 && n < 20) begin
            tick();
            n++;
          end
          chk("sweep4_res", {59'd0, carry4, sum4}, {59'd0, r[4:0]});
          chk("sweep4_latency", 64'(n), 64'd5);
          tick();
          chk("sweep4_idle", {62'd0, busy4, done4}, 64'd0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
